// File: rtl/cmd_sched.sv
// rtl/cmd_sched.sv - button/keyboard command scheduler with hold auto-repeat for the window controller.
module cmd_sched #(
  parameter int HOLD_DLY   = 25_000_000,
  parameter int REPEAT_PER = 5_000_000,
  parameter int CW         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn_req,
  input  logic       kb_valid,
  input  logic [5:0] kb_cmd,
  input  logic       mode_tgl,
  input  logic       run,
  output logic [6:0] win_ctrl_cmd,
  output logic       busy
);

  localparam int M_UP    = 0;
  localparam int M_DOWN  = 1;
  localparam int M_LEFT  = 2;
  localparam int M_RIGHT = 3;
  localparam int Z_IN    = 4;
  localparam int Z_OUT   = 5;
  localparam int M_MODE  = 6;

  typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            slot_vld_q, slot_vld_d;
  logic [2:0]      slot_q, slot_d;
  logic [5:0]      pulse_q, pulse_d;
  logic            mode_q, mode_d;
  logic            emit;
  logic [2:0]      emit_idx;

  function automatic logic [2:0] low_idx(input logic [5:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    pulse_d    = '0;
    emit       = 1'b0;
    emit_idx   = sel_q;
    mode_d     = mode_q ^ mode_tgl;

    case (state_q)
      IDLE: begin
        if (|btn_req) begin
          state_d = FIRST;
          sel_d   = low_idx(btn_req);
        end else if (slot_vld_q) begin
          emit       = 1'b1;
          emit_idx   = slot_q;
          slot_vld_d = 1'b0;
        end
      end
      FIRST: begin
        // Loading the full delay puts the first repeat HOLD_DLY+1 cycles after the first pulse.
        emit    = 1'b1;
        cnt_d   = CW'(HOLD_DLY);
        state_d = HOLD;
      end
      HOLD, REPEAT: begin
        if (!btn_req[sel_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = '0;
        end else if (cnt_q == '0) begin
          emit    = 1'b1;
          cnt_d   = CW'(REPEAT_PER - 1);
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot being served this cycle is already free for an incoming command.
    if (kb_valid && (|kb_cmd) && !slot_vld_d) begin
      slot_vld_d = 1'b1;
      slot_d     = low_idx(kb_cmd);
    end

    if (emit) pulse_d[emit_idx] = 1'b1;
    if (run && !mode_q) pulse_d[M_RIGHT:M_UP] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
      pulse_q    <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
      pulse_q    <= pulse_d;
      mode_q     <= mode_d;
    end
  end

  assign win_ctrl_cmd = {mode_q, pulse_q[Z_OUT:M_UP]};
  assign busy         = (state_q != IDLE) || slot_vld_q;

  logic unused_idx;
  assign unused_idx = (M_DOWN == M_LEFT) || (Z_IN == M_MODE);

endmodule
